// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
// The optional spike counter width (LIF_SPIKE_COUNT_EN builds) also lives here.
package lif_pkg;

  localparam int SPIKE_CNT_W = 16;
  localparam int SAT_W       = 32;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } lif_state_t;

  // Clamp a signed add/sub result into the unsigned range 0 .. 2^width-1.
  function automatic logic [SAT_W-1:0] sat_unsigned(
    input logic signed [SAT_W+1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W+1:0] max_val;
    max_val = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i < int'(width)) max_val[i] = 1'b1;
    end
    if (value[SAT_W+1])        return '0;
    else if (value > max_val)  return max_val[SAT_W-1:0];
    else                       return value[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/lif_leak_timer.sv
// Free-running modulo-LEAK_PERIOD counter; leak_tick marks the last count.
// Runs regardless of the neuron state so leak phase is fixed relative to reset.
module lif_leak_timer
  import lif_pkg::*;
#(
  parameter int LEAK_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  output logic leak_tick
);

  localparam int CNT_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEAK_PERIOD - 1);

  if (LEAK_PERIOD < 1) begin : g_bad_period
    $error("lif_leak_timer: LEAK_PERIOD must be >= 1");
  end

  logic [CNT_W-1:0] leak_cnt;

  assign leak_tick = (leak_cnt == LAST);

  // NOTE: reset is synchronous and active-low here, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst)           leak_cnt <= '0;
    else if (leak_tick) leak_cnt <= '0;
    else                leak_cnt <= leak_cnt + 1'b1;
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrate WEIGHT per spike, linear leak, refractory hold.
// Define LIF_SPIKE_COUNT_EN to add a saturating 16-bit count of fired spikes.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int POT_W          = 8,
  parameter int WEIGHT         = 16,
  parameter int THRESHOLD      = 100,
  parameter int LEAK           = 1,
  parameter int LEAK_PERIOD    = 8,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  output logic             spike_out,
  output logic [POT_W-1:0] potential,
  output logic             refractory
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [SPIKE_CNT_W-1:0] spike_count
`endif
);

  localparam int SUM_W = POT_W + 2;
  localparam int REF_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [1:0] S_INTEGRATE = ST_INTEGRATE;
  localparam logic [1:0] S_FIRE      = ST_FIRE;
  localparam logic [1:0] S_REFRACT   = ST_REFRACT;

  localparam logic signed [SUM_W-1:0] WEIGHT_S = SUM_W'(WEIGHT);
  localparam logic signed [SUM_W-1:0] LEAK_S   = SUM_W'(LEAK);
  localparam logic [POT_W-1:0]        THRESH   = POT_W'(THRESHOLD);

  if (THRESHOLD < 1 || THRESHOLD > (1 << POT_W) - 1) begin : g_bad_threshold
    $error("lif_neuron: THRESHOLD must be within 1 .. 2^POT_W-1");
  end

  logic [1:0]              state;
  logic [REF_W-1:0]        ref_cnt;
  logic                    leak_tick;
  logic signed [SUM_W-1:0] sum;
  logic [POT_W-1:0]        p_n;
  logic                    fire;

  lif_leak_timer #(
    .LEAK_PERIOD (LEAK_PERIOD)
  ) u_leak_timer (
    .clk       (clk),
    .rst       (rst),
    .leak_tick (leak_tick)
  );

  // Spike and leak on the same edge fold into one update before saturation.
  // NOTE: every variable assigned in always_comb gets a value first, so no latch is inferred.
  always_comb begin
    sum = $signed({2'b00, potential});
    if (spike_in)  sum = sum + WEIGHT_S;
    if (leak_tick) sum = sum - LEAK_S;
  end

  assign p_n  = POT_W'(sat_unsigned((SAT_W + 2)'(sum), POT_W));
  assign fire = (p_n >= THRESH);

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_INTEGRATE;
      potential  <= '0;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
      ref_cnt    <= '0;
    end else begin
      case (state)
        S_INTEGRATE: begin
          if (fire) begin
            state      <= S_FIRE;
            spike_out  <= 1'b1;
            refractory <= 1'b1;
            potential  <= '0;
          end else begin
            potential  <= p_n;
          end
        end
        S_FIRE: begin
          spike_out <= 1'b0;
          potential <= '0;
          ref_cnt   <= REF_W'(REFRACT_CYCLES);
          if (REFRACT_CYCLES == 0) begin
            state      <= S_INTEGRATE;
            refractory <= 1'b0;
          end else begin
            state      <= S_REFRACT;
          end
        end
        S_REFRACT: begin
          potential <= '0;
          ref_cnt   <= ref_cnt - 1'b1;
          if (ref_cnt == REF_W'(1)) begin
            state      <= S_INTEGRATE;
            refractory <= 1'b0;
          end
        end
        default: begin
          state      <= S_INTEGRATE;
          potential  <= '0;
          spike_out  <= 1'b0;
          refractory <= 1'b0;
          ref_cnt    <= '0;
        end
      endcase
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      spike_count <= '0;
    end else if (state == S_INTEGRATE && fire && spike_count != '1) begin
      spike_count <= spike_count + 1'b1;
    end
  end
`endif

endmodule
